// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter with a 32-entry pending-write scoreboard.
// Optional same-cycle forwarding of the granted write is enabled by `define REGFILE_ARB_FWD_EN.
module regfile_wport_arb #(
    parameter int NREQ          = 3,
    parameter bit RR_EN_DEFAULT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [4:0]           rsv_addr,
    input  logic [4:0]           qa_addr,
    input  logic [4:0]           qb_addr,
    output logic                 qa_busy,
    output logic                 qb_busy,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 sb_empty
`ifdef REGFILE_ARB_FWD_EN
    ,
    output logic                 qa_fwd,
    output logic                 qb_fwd,
    output logic [31:0]          qa_fdata,
    output logic [31:0]          qb_fdata
`endif
);

    localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]     NREQ_W  = (PW+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] rr_ptr_nxt_s;
    logic [PW-1:0] gnt_idx_s;
    logic          gnt_any_s;
    logic          gnt_wr_s;
    logic [4:0]    gnt_addr_s;
    logic [31:0]   gnt_data_s;
    logic [31:0]   pending_r;
    logic [31:0]   pending_nxt_s;
    logic [31:0]   clr_mask_s;
    logic [31:0]   set_mask_s;
    logic [PW:0]   ptr_inc_s;

    // Winner search: walk requesters from the rotating pointer (or from 0) and keep the first valid one.
    always_comb begin : grant_search
        logic [PW:0] cand;
        logic        hit;
        gnt_any_s = 1'b0;
        gnt_idx_s = {PW{1'b0}};
        cand      = {(PW+1){1'b0}};
        hit       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand      = RR_EN_DEFAULT ? ({1'b0, rr_ptr_r} + (PW+1)'(k)) : (PW+1)'(k);
            cand      = (cand >= NREQ_W) ? (cand - NREQ_W) : cand;
            hit       = !gnt_any_s && req_valid[cand[PW-1:0]];
            gnt_idx_s = hit ? cand[PW-1:0] : gnt_idx_s;
            gnt_any_s = gnt_any_s | hit;
        end
    end

    assign gnt_addr_s = req_addr[5*int'(gnt_idx_s) +: 5];
    assign gnt_data_s = req_data[32*int'(gnt_idx_s) +: 32];
    assign req_ready  = gnt_any_s ? (ONE_HOT << gnt_idx_s) : {NREQ{1'b0}};
    // Writes to r0 complete the handshake but never reach the regfile.
    assign gnt_wr_s   = gnt_any_s && (gnt_addr_s != 5'd0);

    // Next-state for pointer and scoreboard; set is applied after clear so a same-edge reserve wins.
    always_comb begin
        ptr_inc_s     = {1'b0, gnt_idx_s} + {{PW{1'b0}}, 1'b1};
        rr_ptr_nxt_s  = rr_ptr_r;
        clr_mask_s    = 32'd0;
        set_mask_s    = 32'd0;
        if (gnt_any_s) begin
            rr_ptr_nxt_s = (ptr_inc_s == NREQ_W) ? {PW{1'b0}} : ptr_inc_s[PW-1:0];
            clr_mask_s   = 32'd1 << gnt_addr_s;
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
            clr_mask_s   = 32'd0;
        end
        if (rsv_valid) begin
            set_mask_s = 32'd1 << rsv_addr;
        end else begin
            set_mask_s = 32'd0;
        end
        pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // Arbitration pointer and pending-write scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r  <= {PW{1'b0}};
            pending_r <= 32'd0;
        end else begin
            rr_ptr_r  <= rr_ptr_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Registered regfile write port; address/data hold their last written value between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= gnt_wr_s;
            if (gnt_wr_s) begin
                rf_waddr <= gnt_addr_s;
                rf_wdata <= gnt_data_s;
            end else begin
                rf_waddr <= rf_waddr;
                rf_wdata <= rf_wdata;
            end
        end
    end

    assign sb_empty = (pending_r == 32'd0);

`ifdef REGFILE_ARB_FWD_EN
    logic hit_a_s;
    logic hit_b_s;

    // A write granted this cycle to the queried register is forwarded instead of reported busy.
    always_comb begin
        hit_a_s  = gnt_any_s && (qa_addr != 5'd0) && (gnt_addr_s == qa_addr);
        hit_b_s  = gnt_any_s && (qb_addr != 5'd0) && (gnt_addr_s == qb_addr);
        qa_fwd   = hit_a_s;
        qb_fwd   = hit_b_s;
        qa_fdata = hit_a_s ? gnt_data_s : 32'd0;
        qb_fdata = hit_b_s ? gnt_data_s : 32'd0;
        qa_busy  = pending_r[qa_addr] && !hit_a_s;
        qb_busy  = pending_r[qb_addr] && !hit_b_s;
    end
`else
    assign qa_busy = pending_r[qa_addr];
    assign qb_busy = pending_r[qb_addr];
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench: round-robin and fixed-priority instances share stimulus and
// are compared against a per-instance behavioural model (index 0 = RR, 1 = fixed).
module tb_regfile_wport_arb;

    localparam int NREQ = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [5*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]  req_data;
    logic                rsv_valid;
    logic [4:0]          rsv_addr;
    logic [4:0]          qa_addr;
    logic [4:0]          qb_addr;

    logic [NREQ-1:0]     o_rdy [2];
    logic                o_qa_busy [2];
    logic                o_qb_busy [2];
    logic                o_we [2];
    logic [4:0]          o_wa [2];
    logic [31:0]         o_wd [2];
    logic                o_se [2];
`ifdef REGFILE_ARB_FWD_EN
    logic                o_qa_fwd [2];
    logic                o_qb_fwd [2];
    logic [31:0]         o_qa_fd [2];
    logic [31:0]         o_qb_fd [2];
`endif

    int n_vec = 0;
    int n_err = 0;

    // model state per instance
    logic [31:0] m_pend [2];
    int          m_ptr [2];
    logic        m_we [2];
    logic [4:0]  m_wa [2];
    logic [31:0] m_wd [2];
    int          m_last_g [2];

    always #5 clk = ~clk;

    regfile_wport_arb #(.NREQ(NREQ), .RR_EN_DEFAULT(1'b1)) dut_rr (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(o_rdy[0]), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .qa_addr(qa_addr), .qb_addr(qb_addr),
        .qa_busy(o_qa_busy[0]), .qb_busy(o_qb_busy[0]), .rf_we(o_we[0]),
        .rf_waddr(o_wa[0]), .rf_wdata(o_wd[0]), .sb_empty(o_se[0])
`ifdef REGFILE_ARB_FWD_EN
        , .qa_fwd(o_qa_fwd[0]), .qb_fwd(o_qb_fwd[0]),
        .qa_fdata(o_qa_fd[0]), .qb_fdata(o_qb_fd[0])
`endif
    );

    regfile_wport_arb #(.NREQ(NREQ), .RR_EN_DEFAULT(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(o_rdy[1]), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .qa_addr(qa_addr), .qb_addr(qb_addr),
        .qa_busy(o_qa_busy[1]), .qb_busy(o_qb_busy[1]), .rf_we(o_we[1]),
        .rf_waddr(o_wa[1]), .rf_wdata(o_wd[1]), .sb_empty(o_se[1])
`ifdef REGFILE_ARB_FWD_EN
        , .qa_fwd(o_qa_fwd[1]), .qb_fwd(o_qb_fwd[1]),
        .qa_fdata(o_qa_fd[1]), .qb_fdata(o_qb_fd[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
    endtask

    // Winner per the arbitration rule: first valid index scanning from the pointer (RR) or from 0.
    function automatic int model_grant(input int m);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m == 0) ? (m_ptr[m] + k) % NREQ : k;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 32'd0; m_ptr[m] = 0; m_we[m] = 1'b0;
            m_wa[m] = 5'd0; m_wd[m] = 32'd0; m_last_g[m] = -1;
        end
    endtask

    task automatic check_comb();
        for (int m = 0; m < 2; m++) begin
            int g;
            logic ea, eb, fa, fb;
            logic [4:0] ga;
            g  = model_grant(m);
            ga = (g >= 0) ? req_addr[5*g +: 5] : 5'd0;
            ea = m_pend[m][qa_addr] && (qa_addr != 5'd0);
            eb = m_pend[m][qb_addr] && (qb_addr != 5'd0);
            fa = 1'b0; fb = 1'b0;
`ifdef REGFILE_ARB_FWD_EN
            fa = (g >= 0) && (qa_addr != 5'd0) && (ga == qa_addr);
            fb = (g >= 0) && (qb_addr != 5'd0) && (ga == qb_addr);
            chk($sformatf("qa_fwd_m%0d", m), o_qa_fwd[m], fa);
            chk($sformatf("qb_fwd_m%0d", m), o_qb_fwd[m], fb);
            if (fa) chk($sformatf("qa_fdata_m%0d", m), o_qa_fd[m], req_data[32*g +: 32]);
            if (fb) chk($sformatf("qb_fdata_m%0d", m), o_qb_fd[m], req_data[32*g +: 32]);
`endif
            chk($sformatf("ready_m%0d", m), o_rdy[m], (g >= 0) ? (32'd1 << g) : 32'd0);
            chk($sformatf("qa_busy_m%0d", m), o_qa_busy[m], ea && !fa);
            chk($sformatf("qb_busy_m%0d", m), o_qb_busy[m], eb && !fb);
            chk($sformatf("sb_empty_m%0d", m), o_se[m], m_pend[m] == 32'd0);
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int g;
            logic [4:0] a;
            g = model_grant(m);
            m_last_g[m] = g;
            m_we[m] = 1'b0;
            if (g >= 0) begin
                a = req_addr[5*g +: 5];
                m_ptr[m] = (g + 1) % NREQ;
                m_pend[m][a] = 1'b0;
                if (a != 5'd0) begin
                    m_we[m] = 1'b1; m_wa[m] = a; m_wd[m] = req_data[32*g +: 32];
                end
            end
            if (rsv_valid && rsv_addr != 5'd0) m_pend[m][rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_reg();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rf_we_m%0d", m), o_we[m], m_we[m]);
            if (m_we[m]) begin
                chk($sformatf("rf_waddr_m%0d", m), o_wa[m], m_wa[m]);
                chk($sformatf("rf_wdata_m%0d", m), o_wd[m], m_wd[m]);
            end
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the following negedge.
    task automatic cycle();
        #2;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_reg();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_addr = 5'd0; qa_addr = 5'd0; qb_addr = 5'd0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_we", o_we[m], 1'b0);
            chk("rst_waddr", o_wa[m], 5'd0);
            chk("rst_wdata", o_wd[m], 32'd0);
            chk("rst_sb_empty", o_se[m], 1'b1);
            chk("rst_ready", o_rdy[m], 3'b000);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // reserve r5, then retire it through requester 0
        rsv_valid = 1'b1; rsv_addr = 5'd5; cycle(); rsv_valid = 1'b0;
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF); qa_addr = 5'd5;
        #1 chk("raw_busy_before", o_qa_busy[0], 1'b1);
        cycle();
        chk("raw_we", o_we[0], 1'b1);
        chk("raw_waddr", o_wa[0], 5'd5);
        chk("raw_wdata", o_wd[0], 32'hDEADBEEF);
        chk("raw_busy_after", o_qa_busy[0], 1'b0);
        set_req(0, 1'b0, 5'd0, 32'd0);

        // all requesters continuously valid
        set_req(0, 1'b1, 5'd1, 32'h1111_0001);
        set_req(1, 1'b1, 5'd2, 32'h2222_0002);
        set_req(2, 1'b1, 5'd3, 32'h3333_0003);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("b2b_we_rr", o_we[0], 1'b1);
            chk("fp_waddr", o_wa[1], 5'd1);
        end
        req_valid = '0;

        // reserve and retire r7 on the same edge
        rsv_valid = 1'b1; rsv_addr = 5'd7; cycle();
        set_req(0, 1'b1, 5'd7, 32'h0000_0777); cycle();
        set_req(0, 1'b0, 5'd0, 32'd0); rsv_valid = 1'b0; qa_addr = 5'd7;
        #1 chk("rsv_wins", o_qa_busy[0], 1'b1);
        cycle();

        // r0 write: accepted, no regfile write; r0 reservation ignored
        set_req(1, 1'b1, 5'd0, 32'h0000_1234);
        #1 chk("r0_ready", o_rdy[0], 3'b010);
        cycle();
        chk("r0_no_we", o_we[0], 1'b0);
        set_req(1, 1'b0, 5'd0, 32'd0);
        rsv_valid = 1'b1; rsv_addr = 5'd0; qa_addr = 5'd0; cycle();
        rsv_valid = 1'b0;
        chk("r0_busy", o_qa_busy[0], 1'b0);
        chk("r0_sb_empty", o_se[0], 1'b0);

`ifdef REGFILE_ARB_FWD_EN
        rsv_valid = 1'b1; rsv_addr = 5'd9; cycle(); rsv_valid = 1'b0;
        set_req(2, 1'b1, 5'd9, 32'hA5A5A5A5); qa_addr = 5'd9;
        #1;
        chk("fwd_flag", o_qa_fwd[0], 1'b1);
        chk("fwd_data", o_qa_fd[0], 32'hA5A5A5A5);
        chk("fwd_busy", o_qa_busy[0], 1'b0);
        cycle();
        set_req(2, 1'b0, 5'd0, 32'd0);
`endif

        // reset while a write pulse is on the port
        set_req(0, 1'b1, 5'd12, 32'hCAFE_F00D); rsv_valid = 1'b1; rsv_addr = 5'd20;
        cycle();
        set_req(0, 1'b0, 5'd0, 32'd0); rsv_valid = 1'b0;
        chk("mid_we_high", o_we[0], 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we", o_we[0], 1'b0);
        chk("mid_rst_we_fp", o_we[1], 1'b0);
        chk("mid_rst_sb_empty", o_se[0], 1'b1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // random traffic; requesters release only when the driving instance accepts them
        for (int drv = 0; drv < 2; drv++) begin
            for (int n = 0; n < 300; n++) begin
                int slot;
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && ($urandom % 3 != 0))
                        set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
                end
                rsv_valid = ($urandom % 4 == 0);
                rsv_addr  = 5'($urandom_range(0, 31));
                slot      = $urandom_range(0, NREQ - 1);
                qa_addr   = ($urandom % 2 == 0) ? req_addr[5*slot +: 5] : 5'($urandom_range(0, 31));
                qb_addr   = 5'($urandom_range(0, 31));
                cycle();
                if (m_last_g[drv] >= 0) set_req(m_last_g[drv], 1'b0, 5'd0, 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arb.md
Name: regfile_wport_arb

Overview:
- Shares the single register-file write port (wenable / c_addr / c_newdata) among N writeback requesters, e.g. ALU, load unit and MUL/DIV/CP0 move unit.
- Keeps a 32-entry pending-write scoreboard so decode can stall on RAW hazards against in-flight multi-cycle producers.
- Sits between the execute/memory writeback sources and the regfile; issue logic reserves destinations, and the arbiter clears them as writes retire.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- RR_EN_DEFAULT, 1, 1 = round-robin arbitration, 0 = fixed priority (index 0 highest).

Ports:
- clk  in  1  system clock, posedge-active.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  5*NREQ  destination register, slice i = [5i+4:5i].
- req_data  in  32*NREQ  write data, slice i = [32i+31:32i].
- req_ready  out  NREQ  one-hot grant; handshake completes on the edge where valid&ready.
- rsv_valid  in  1  issue stage reserves a destination this cycle.
- rsv_addr  in  5  register being reserved.
- qa_addr  in  5  hazard query A (rs).
- qb_addr  in  5  hazard query B (rt).
- qa_busy  out  1  rs has an outstanding write.
- qb_busy  out  1  rt has an outstanding write.
- rf_we  out  1  regfile wenable, registered.
- rf_waddr  out  5  regfile c_addr, registered.
- rf_wdata  out  32  regfile c_newdata, registered.
- sb_empty  out  1  no pending bits set.

Behaviour:
- Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, pending[31:0]=0, rr_ptr=0, req_ready=0, sb_empty=1.
- Grant (combinational):
  - Round-robin: search from rr_ptr upward, with wrap, for the first asserted req_valid.
  - Fixed priority: lowest asserted index wins.
  - At most one req_ready bit high; req_ready=0 when no valid.
  - req_ready never asserts for a non-valid requester.
- Requesters hold valid/addr/data stable until accepted.
- rr_ptr update: on an accepted grant at index g, rr_ptr <= (g+1) mod NREQ. Unchanged when idle.
- Write latency: 1 cycle. On the accepting edge, rf_we<=1, rf_waddr<=addr, rf_wdata<=data. rf_we is a 1-cycle pulse; the next edge loads 0 unless another grant occurs. Back-to-back grants give continuous rf_we.
- Register 0:
  - A request with addr 0 is accepted (ready asserted, handshake completes) but rf_we stays 0.
  - rsv_addr 0 is ignored.
  - pending[0] is always 0; qa_busy/qb_busy are 0 for address 0.
- Scoreboard:
  - rsv_valid sets pending[rsv_addr] on the edge.
  - An accepted grant clears pending[addr] on the edge.
  - Same register reserved and cleared on the same edge: reserve wins, bit stays 1.
  - Reserving an already-pending register keeps it 1 (single bit, no count).
  - Clearing a non-pending register is harmless.
- Query: qX_busy = pending[qX_addr], combinational. Cleared in the rf_we cycle; the regfile captures on the negedge of that cycle, so same-cycle decode reads are valid.
- sb_empty = (pending == 0), combinational.
- Reset mid-operation: all pending bits are dropped, any in-flight rf_we is cancelled immediately, and rr_ptr returns to 0.

Optional Feature:
- Macro: REGFILE_ARB_FWD_EN.
- Defined: adds outputs qa_fwd, qb_fwd (1) and qa_fdata, qb_fdata (32).
  - If this cycle's granted request targets a queried nonzero address, qX_fwd=1, qX_fdata = that request's data, and qX_busy is forced 0.
  - Lets decode proceed one cycle early.
- Undefined: ports absent; busy is derived purely from pending.

Test Plan:
- Reset, then idle → rf_we=0, sb_empty=1, req_ready=0; assert reset mid-write (rf_we=1) → rf_we drops immediately, pending cleared.
- rsv $5; later req0 valid addr=5 data=0xDEADBEEF → qa_busy(5)=1 until the grant edge; the next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, qa_busy=0.
- All 3 requesters valid continuously (addrs 1,2,3), RR → grants 0,1,2,0,… one per cycle; rf_we continuously 1; same with RR_EN_DEFAULT=0 → always grant 0.
- rsv_valid addr=7 on the same edge a grant for addr 7 is accepted → pending[7] remains 1, qa_busy(7)=1.
- req1 addr=0 data=0x1234 → req_ready[1]=1, rf_we stays 0; rsv addr 0 → qa_busy(0)=0, sb_empty unchanged.
- With REGFILE_ARB_FWD_EN: pending $9, req2 addr=9 data=0xA5A5A5A5, qa_addr=9 → same cycle qa_fwd=1, qa_fdata=0xA5A5A5A5, qa_busy=0.
